// File: rtl/mem_access_if.sv
// Data-memory handshake bus between the LC3 memory-access stage and data memory.
//   dmem_req  : request, held until a clock edge samples dmem_ack=1
//   dmem_rd   : 1 = read, 0 = write
//   dmem_addr : memory address
//   dmem_din  : write data (stage -> memory)
//   dmem_dout : read data (memory -> stage), valid with dmem_ack
//   dmem_ack  : completion from memory
// master = memory-access stage, slave = data memory.
interface mem_access_if;
  logic        dmem_req;
  logic        dmem_rd;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_din;
  logic [15:0] dmem_dout;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_rd, dmem_addr, dmem_din,
    input  dmem_dout, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_rd, dmem_addr, dmem_din,
    output dmem_dout, dmem_ack
  );
endinterface

// File: rtl/mem_access.sv
// LC3 memory-access pipeline stage. Runs LD/LDR/LDI/ST/STR/STI against a
// handshaked data-memory port; LDI/STI first fetch a pointer, then access it.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   enable_mem        : stage enable, op accepted only when idle
//   Mem_Control_in    : 1 = instruction is a memory op
//   W_Control_in      : writeback control from execute
//   IR_Exec           : instruction (opcode [15:12], dr [11:9])
//   pcout             : effective address
//   M_Data            : store data
//   dmem              : data-memory bus (master side)
//   memout            : load result / bypass value
//   W_Control_out     : registered writeback control of accepted op
//   dr_out            : registered destination register
//   mem_done, mem_err : one-cycle completion / timeout-abort pulses
//   mem_busy          : stall to upstream, high while not idle
module mem_access #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable_mem,
  input  logic         Mem_Control_in,
  input  logic [1:0]   W_Control_in,
  input  logic [15:0]  IR_Exec,
  input  logic [15:0]  pcout,
  input  logic [15:0]  M_Data,
  mem_access_if.master dmem,
  output logic [15:0]  memout,
  output logic [1:0]   W_Control_out,
  output logic [2:0]   dr_out,
  output logic         mem_done,
  output logic         mem_err,
  output logic         mem_busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_IND    = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;

  logic [1:0]  state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [3:0]  op_q, op_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] memout_q, memout_d;
  logic [1:0]  wctl_q, wctl_d;
  logic [2:0]  dr_q, dr_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [3:0]  opc;
  logic        is_direct;
  logic        is_indirect;
  logic        is_load;
  logic        timeout_hit;
  logic [15:0] cnt_inc;
  logic        unused_ir;

  assign opc         = IR_Exec[15:12];
  assign unused_ir   = ^IR_Exec[8:0];
  assign is_direct   = (opc == OP_LD) || (opc == OP_LDR) || (opc == OP_ST) || (opc == OP_STR);
  assign is_indirect = (opc == OP_LDI) || (opc == OP_STI);
  assign is_load     = (op_q == OP_LD) || (op_q == OP_LDR) || (op_q == OP_LDI);

  // Abort fires on the edge that would bring the counter up to ACK_TIMEOUT.
  assign timeout_hit = (ACK_TIMEOUT != 0) && (({16'd0, cnt_q} + 32'd1) >= ACK_TIMEOUT);
  assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    memout_d = memout_q;
    wctl_d   = wctl_q;
    dr_d     = dr_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable_mem) begin
          wctl_d = W_Control_in;
          dr_d   = IR_Exec[11:9];
          if (Mem_Control_in && (is_direct || is_indirect)) begin
            addr_d  = pcout;
            data_d  = M_Data;
            op_d    = opc;
            cnt_d   = '0;
            state_d = is_indirect ? S_IND : S_ACCESS;
          end
        end
      end
      S_IND: begin
        if (dmem.dmem_ack) begin
          addr_d  = dmem.dmem_dout;
          cnt_d   = '0;
          state_d = S_ACCESS;
        end else if (timeout_hit) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_ACCESS: begin
        if (dmem.dmem_ack) begin
          if (is_load) begin
            memout_d = dmem.dmem_dout;
          end
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (timeout_hit) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      memout_q <= '0;
      wctl_q   <= '0;
      dr_q     <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      memout_q <= memout_d;
      wctl_q   <= wctl_d;
      dr_q     <= dr_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Bus outputs decode from registered state only, so they stay stable until ack.
  always_comb begin
    mem_busy       = (state_q != S_IDLE);
    dmem.dmem_req  = mem_busy;
    dmem.dmem_rd   = (state_q == S_IND) || ((state_q == S_ACCESS) && is_load);
    dmem.dmem_addr = mem_busy ? addr_q : '0;
    dmem.dmem_din  = ((state_q == S_ACCESS) && !is_load) ? data_q : '0;
  end

  assign memout        = memout_q;
  assign W_Control_out = wctl_q;
  assign dr_out        = dr_q;
  assign mem_done      = done_q;
  assign mem_err       = err_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: transaction-level reference model,
// per-cycle output compare, and directed literal checks.
module tb_mem_access;
  localparam int unsigned TO = 4;

  typedef struct {
    logic        rd;
    logic        ptr;
    logic [15:0] addr;
    logic [15:0] data;
  } bus_op_t;

  typedef struct {
    logic        rd;
    logic [15:0] addr;
    logic [15:0] din;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_mem;
  logic        Mem_Control_in;
  logic [1:0]  W_Control_in;
  logic [15:0] IR_Exec;
  logic [15:0] pcout;
  logic [15:0] M_Data;
  logic [15:0] memout;
  logic [1:0]  W_Control_out;
  logic [2:0]  dr_out;
  logic        mem_done;
  logic        mem_err;
  logic        mem_busy;

  mem_access_if bus();

  mem_access #(.ACK_TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable_mem     (enable_mem),
    .Mem_Control_in (Mem_Control_in),
    .W_Control_in   (W_Control_in),
    .IR_Exec        (IR_Exec),
    .pcout          (pcout),
    .M_Data         (M_Data),
    .dmem           (bus.master),
    .memout         (memout),
    .W_Control_out  (W_Control_out),
    .dr_out         (dr_out),
    .mem_done       (mem_done),
    .mem_err        (mem_err),
    .mem_busy       (mem_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  logic [15:0] mem [0:65535];
  int wait_cfg   = 0;
  int ack_budget = -1;   // -1 = unlimited acks
  int wcnt       = 0;

  initial begin
    bus.dmem_ack  = 1'b0;
    bus.dmem_dout = 16'h0;
  end

  always @(negedge clk) begin
    if (bus.dmem_req && !rst && ack_budget != 0) begin
      if (wcnt >= wait_cfg) begin
        bus.dmem_ack  = 1'b1;
        bus.dmem_dout = bus.dmem_rd ? mem[bus.dmem_addr] : 16'h0;
        wcnt = 0;
        if (ack_budget > 0) ack_budget--;
      end else begin
        bus.dmem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      bus.dmem_ack = 1'b0;
      wcnt = 0;
    end
  end

  // ---------------- completed-transaction log and pulse counters ----------------
  txn_t log_q[$];
  int n_done = 0;
  int n_err  = 0;
  int n_busy = 0;

  always @(posedge clk) begin
    if (!rst && bus.dmem_req && bus.dmem_ack)
      log_q.push_back('{rd: bus.dmem_rd, addr: bus.dmem_addr, din: bus.dmem_din});
  end

  always @(negedge clk) begin
    if (mem_done) n_done++;
    if (mem_err)  n_err++;
    if (mem_busy) n_busy++;
  end

  // ---------------- reference model (list of pending bus operations) ----------------
  bus_op_t     m_q[$];
  int          m_wait = 0;
  logic [15:0] m_memout = 16'h0;
  logic [1:0]  m_wctl = 2'b0;
  logic [2:0]  m_dr = 3'b0;
  logic        m_done = 1'b0;
  logic        m_err = 1'b0;
  logic        started = 1'b0;

  always @(posedge clk) begin
    bus_op_t hd;
    bus_op_t nx;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (rst) begin
      m_q.delete();
      m_wait = 0; m_memout = 16'h0; m_wctl = 2'b0; m_dr = 3'b0;
      started = 1'b1;
    end else if (m_q.size() == 0) begin
      if (enable_mem) begin
        m_wctl = W_Control_in;
        m_dr   = IR_Exec[11:9];
        m_wait = 0;
        if (Mem_Control_in) begin
          case (IR_Exec[15:12])
            4'b0010, 4'b0110: m_q.push_back('{rd: 1'b1, ptr: 1'b0, addr: pcout, data: M_Data});
            4'b0011, 4'b0111: m_q.push_back('{rd: 1'b0, ptr: 1'b0, addr: pcout, data: M_Data});
            4'b1010: begin
              m_q.push_back('{rd: 1'b1, ptr: 1'b1, addr: pcout, data: 16'h0});
              m_q.push_back('{rd: 1'b1, ptr: 1'b0, addr: 16'h0, data: M_Data});
            end
            4'b1011: begin
              m_q.push_back('{rd: 1'b1, ptr: 1'b1, addr: pcout, data: 16'h0});
              m_q.push_back('{rd: 1'b0, ptr: 1'b0, addr: 16'h0, data: M_Data});
            end
            default: ;
          endcase
        end
      end
    end else if (bus.dmem_ack) begin
      hd = m_q.pop_front();
      m_wait = 0;
      if (hd.ptr) begin
        nx = m_q.pop_front();
        nx.addr = bus.dmem_dout;
        m_q.push_front(nx);
      end else begin
        m_done = 1'b1;
        if (hd.rd) m_memout = bus.dmem_dout;
      end
    end else begin
      m_wait++;
      if (TO != 0 && m_wait >= int'(TO)) begin
        m_q.delete();
        m_wait = 0;
        m_err  = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic        e_req, e_rd;
    logic [15:0] e_addr, e_din;
    if (started) begin
      e_req = (m_q.size() != 0);
      e_rd = 1'b0; e_addr = 16'h0; e_din = 16'h0;
      if (e_req) begin
        e_rd   = m_q[0].rd;
        e_addr = m_q[0].addr;
        e_din  = m_q[0].rd ? 16'h0 : m_q[0].data;
      end
      check("dmem_req",      16'(bus.dmem_req),  16'(e_req));
      check("dmem_rd",       16'(bus.dmem_rd),   16'(e_rd));
      check("dmem_addr",     bus.dmem_addr,      e_addr);
      check("dmem_din",      bus.dmem_din,       e_din);
      check("memout",        memout,             m_memout);
      check("W_Control_out", 16'(W_Control_out), 16'(m_wctl));
      check("dr_out",        16'(dr_out),        16'(m_dr));
      check("mem_done",      16'(mem_done),      16'(m_done));
      check("mem_err",       16'(mem_err),       16'(m_err));
      check("mem_busy",      16'(mem_busy),      16'(e_req));
    end
  end

  // ---------------- stimulus ----------------
  int s_done, s_err, s_busy, s_log;

  task automatic snap();
    s_done = n_done; s_err = n_err; s_busy = n_busy; s_log = log_q.size();
  endtask

  task automatic wait_idle();
    int k = 0;
    while (mem_busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (mem_busy) check("busy_bound", 16'(mem_busy), 16'h0);
  endtask

  task automatic drive(input logic [3:0] op, input logic [2:0] dr, input logic mc,
                       input logic [1:0] wc, input logic [15:0] pc, input logic [15:0] md);
    enable_mem = 1'b1; Mem_Control_in = mc; W_Control_in = wc;
    IR_Exec = {op, dr, 9'h0A5}; pcout = pc; M_Data = md;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [2:0] dr, input logic mc,
                        input logic [1:0] wc, input logic [15:0] pc, input logic [15:0] md);
    @(negedge clk);
    drive(op, dr, mc, wc, pc, md);
    @(negedge clk);
    enable_mem = 1'b0; IR_Exec = 16'hFFFF; pcout = 16'hDEAD; M_Data = 16'hDEAD;
    wait_idle();
    repeat (3) @(negedge clk);
  endtask

  task automatic check_txn(input string name, input int idx, input logic rd,
                           input logic [15:0] addr, input logic [15:0] din);
    if (idx >= log_q.size()) begin
      check({name, "_missing"}, 16'(log_q.size()), 16'(idx + 1));
    end else begin
      check({name, "_rd"},   16'(log_q[idx].rd), 16'(rd));
      check({name, "_addr"}, log_q[idx].addr,    addr);
      check({name, "_din"},  log_q[idx].din,     din);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
    mem[16'h3000] = 16'hBEEF;
    mem[16'h3002] = 16'h1111;
    mem[16'h3004] = 16'h2222;
    mem[16'h5000] = 16'h6000;
    mem[16'h6000] = 16'h00AA;
    mem[16'h5100] = 16'h6100;
    mem[16'h6100] = 16'h4321;

    rst = 1'b1; enable_mem = 1'b0; Mem_Control_in = 1'b0; W_Control_in = 2'b0;
    IR_Exec = 16'h0; pcout = 16'h0; M_Data = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_req",    16'(bus.dmem_req), 16'h0);
    check("rst_memout", memout,            16'h0);
    check("rst_busy",   16'(mem_busy),     16'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // LD, zero-wait
    snap();
    run_op(4'b0010, 3'd1, 1'b1, 2'b01, 16'h3000, 16'h0);
    check("ld_memout", memout, 16'hBEEF);
    check("ld_done",   16'(n_done - s_done), 16'd1);
    check("ld_busy",   16'(n_busy - s_busy), 16'd1);
    check("ld_dr",     16'(dr_out), 16'd1);
    check_txn("ld_txn", s_log, 1'b1, 16'h3000, 16'h0);

    // STR, ack after 3 wait cycles (ack lands on the timeout edge and wins)
    wait_cfg = 3;
    snap();
    run_op(4'b0111, 3'd2, 1'b1, 2'b00, 16'h4010, 16'h1234);
    check("str_memout", memout, 16'hBEEF);
    check("str_done",   16'(n_done - s_done), 16'd1);
    check("str_err",    16'(n_err - s_err),   16'd0);
    check("str_busy",   16'(n_busy - s_busy), 16'd4);
    check_txn("str_txn", s_log, 1'b0, 16'h4010, 16'h1234);
    wait_cfg = 0;

    // LDI
    snap();
    run_op(4'b1010, 3'd3, 1'b1, 2'b10, 16'h5000, 16'h0);
    check("ldi_memout", memout, 16'h00AA);
    check("ldi_busy",   16'(n_busy - s_busy), 16'd2);
    check("ldi_done",   16'(n_done - s_done), 16'd1);
    check_txn("ldi_ptr", s_log,     1'b1, 16'h5000, 16'h0);
    check_txn("ldi_acc", s_log + 1, 1'b1, 16'h6000, 16'h0);

    // STI
    mem[16'h5000] = 16'h7000;
    snap();
    run_op(4'b1011, 3'd4, 1'b1, 2'b00, 16'h5000, 16'h0055);
    check("sti_memout", memout, 16'h00AA);
    check("sti_busy",   16'(n_busy - s_busy), 16'd2);
    check_txn("sti_ptr", s_log,     1'b1, 16'h5000, 16'h0);
    check_txn("sti_acc", s_log + 1, 1'b0, 16'h7000, 16'h0055);

    // Back-to-back: second op accepted in the mem_done cycle
    snap();
    @(negedge clk);
    drive(4'b0010, 3'd2, 1'b1, 2'b01, 16'h3002, 16'h0);
    @(negedge clk);
    drive(4'b0110, 3'd3, 1'b1, 2'b01, 16'h3004, 16'h0);
    wait_idle();
    @(negedge clk);
    enable_mem = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("b2b_done",   16'(n_done - s_done), 16'd2);
    check("b2b_busy",   16'(n_busy - s_busy), 16'd2);
    check("b2b_memout", memout, 16'h2222);
    check("b2b_dr",     16'(dr_out), 16'd3);

    // Timeout: no ack at all
    ack_budget = 0;
    snap();
    run_op(4'b0010, 3'd4, 1'b1, 2'b11, 16'h4100, 16'h0);
    check("to_err",    16'(n_err - s_err),   16'd1);
    check("to_done",   16'(n_done - s_done), 16'd0);
    check("to_busy",   16'(n_busy - s_busy), 16'd4);
    check("to_memout", memout, 16'h2222);
    check("to_req",    16'(bus.dmem_req), 16'h0);
    ack_budget = -1;

    // Reset while LDI is in its final access
    ack_budget = 1;
    snap();
    @(negedge clk);
    drive(4'b1010, 3'd6, 1'b1, 2'b10, 16'h5100, 16'h0);
    @(negedge clk);
    enable_mem = 1'b0;
    @(negedge clk);
    check("rmid_req",  16'(bus.dmem_req), 16'h1);
    check("rmid_addr", bus.dmem_addr,     16'h6100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rmid_req0",   16'(bus.dmem_req),  16'h0);
    check("rmid_memout", memout,             16'h0);
    check("rmid_wctl",   16'(W_Control_out), 16'h0);
    check("rmid_dr",     16'(dr_out),        16'h0);
    check("rmid_busy",   16'(mem_busy),      16'h0);
    ack_budget = -1;
    repeat (3) @(negedge clk);
    check("rmid_done", 16'(n_done - s_done), 16'd0);
    check("rmid_err",  16'(n_err - s_err),   16'd0);

    // ADD (not a memory op): only W_Control/dr latch
    snap();
    run_op(4'b0001, 3'd5, 1'b0, 2'b11, 16'h1234, 16'h0);
    check("add_busy", 16'(n_busy - s_busy), 16'd0);
    check("add_txn",  16'(log_q.size() - s_log), 16'd0);
    check("add_wctl", 16'(W_Control_out), 16'd3);
    check("add_dr",   16'(dr_out), 16'd5);
    check("add_memout", memout, 16'h0);

    // LD opcode with Mem_Control_in=0: no traffic
    snap();
    run_op(4'b0010, 3'd7, 1'b0, 2'b01, 16'h3000, 16'h0);
    check("nomc_busy", 16'(n_busy - s_busy), 16'd0);
    check("nomc_dr",   16'(dr_out), 16'd7);
    check("nomc_memout", memout, 16'h0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access pipeline stage of the LC3 core; sits directly after the execute stage and consumes its registered outputs (pcout, M_Data, IR_Exec, Mem_Control, W_Control).
- Runs LD/LDR/LDI/ST/STR/STI against a handshaked data-memory port. Indirect ops (LDI/STI) use a pointer-fetch read first.
- Produces the load result for writeback and bypass, and a busy/stall signal for the controller.

Parameters:
- ACK_TIMEOUT, 16: max cycles a request waits for dmem_ack before aborting; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- enable_mem  in  1  stage enable; op accepted only when high and state IDLE
- Mem_Control_in  in  1  1 = instruction is a memory op
- W_Control_in  in  2  writeback control from execute
- IR_Exec  in  16  instruction from execute; opcode [15:12], dr [11:9]
- pcout  in  16  effective address from execute
- M_Data  in  16  store data from execute
- dmem_req  out  1  memory request, held until ack
- dmem_rd  out  1  1 = read, 0 = write
- dmem_addr  out  16  memory address
- dmem_din  out  16  write data
- dmem_dout  in  16  read data, valid with dmem_ack
- dmem_ack  in  1  memory completion
- memout  out  16  load result and Mem_Bypass_val source
- W_Control_out  out  2  registered W_Control of accepted op
- dr_out  out  3  registered destination register
- mem_done  out  1  one-cycle pulse when a memory op completes
- mem_err  out  1  one-cycle pulse on timeout abort
- mem_busy  out  1  stall to upstream, = (state != IDLE)

Behaviour:
- Reset values: state IDLE, memout 0, W_Control_out 0, dr_out 0, mem_done 0, mem_err 0, internal addr/data/opcode regs 0, timeout counter 0. dmem_req is 0 from the reset edge onward.
- Reset mid-operation: abort immediately to IDLE with no done and no err. An outstanding ack is ignored.
- States: IDLE, IND (pointer read), ACCESS (final read or write).
- IDLE, enable_mem=1:
  - Latch W_Control_in into W_Control_out and IR_Exec[11:9] into dr_out.
  - If Mem_Control_in=1 and opcode is one of 0010 LD, 0110 LDR, 0011 ST, 0111 STR: latch addr=pcout, data=M_Data, opcode; go to ACCESS.
  - If Mem_Control_in=1 and opcode is 1010 LDI or 1011 STI: latch the same fields; go to IND.
  - Any other case: stay IDLE, no memory traffic, memout unchanged.
- IDLE, enable_mem=0: hold all outputs.
- Inputs are ignored while busy; upstream must stall on mem_busy.
- Outputs by state:
  - IND: dmem_req=1, dmem_rd=1, dmem_addr=addr, dmem_din=0.
  - ACCESS load: dmem_req=1, dmem_rd=1, dmem_addr=addr, dmem_din=0.
  - ACCESS store: dmem_req=1, dmem_rd=0, dmem_addr=addr, dmem_din=data.
  - IDLE: dmem_req=0, dmem_rd=0, dmem_addr=0, dmem_din=0.
- Handshake:
  - dmem_req, dmem_rd, dmem_addr and dmem_din are held stable until a clock edge samples dmem_ack=1.
  - dmem_ack is ignored in IDLE.
  - Zero-wait memory (ack in the first req cycle) is legal.
- IND + ack: addr <= dmem_dout; go to ACCESS; timeout counter cleared.
- ACCESS + ack:
  - Load: memout <= dmem_dout.
  - Store: memout unchanged.
  - Both: mem_done=1 for the next cycle; go to IDLE.
- Timeout (ACK_TIMEOUT>0):
  - Counter increments on each edge in IND/ACCESS without ack and clears on state entry.
  - On reaching ACK_TIMEOUT: go to IDLE, mem_err=1 for one cycle, no mem_done, memout unchanged.
  - An ack on the same edge as the timeout wins: normal completion.
- Latency, with the accept edge as T0 and zero-wait memory:
  - LD/ST: mem_done high in cycle T1–T2.
  - LDI/STI: mem_done high in cycle T2–T3.
  - Each wait cycle adds one cycle.
- Back-to-back: a new op can be accepted on the edge right after returning to IDLE, i.e. the cycle mem_done is high.
- Widths are 16-bit throughout; no arithmetic beyond the 16-bit timeout counter (saturates, no wrap).

Test Plan:
- Reset, then LD: opcode 0010, pcout=0x3000, memory[0x3000]=0xBEEF, ack same cycle → dmem_addr=0x3000, dmem_rd=1; memout=0xBEEF; mem_done pulses once, 2 cycles after accept; mem_busy high exactly 1 cycle.
- STR: pcout=0x4010, M_Data=0x1234, ack after 3 wait cycles → dmem_rd=0, dmem_din=0x1234 stable for all 4 req cycles; memout unchanged; mem_done once.
- LDI: pcout=0x5000, mem[0x5000]=0x6000, mem[0x6000]=0x00AA → two reads at 0x5000 then 0x6000; memout=0x00AA; mem_busy 2 cycles.
- STI: pcout=0x5000, mem[0x5000]=0x7000, M_Data=0x55 → read 0x5000, then write 0x55 to 0x7000.
- Timeout: ACK_TIMEOUT=4, no ack → mem_err pulse after 4 req cycles; state IDLE; no mem_done; dmem_req low. Variant: ack on the 4th edge → mem_done, no mem_err.
- rst asserted mid-LDI in ACCESS → next cycle dmem_req=0, all outputs 0. Separately, ADD with Mem_Control_in=0 → no dmem_req, W_Control_out and dr_out latched, mem_busy stays 0.
